// File: rtl/dsp_file_port_arbiter.sv
// dsp_file_port_arbiter
// Shares one DSP file-controller port among NUM_REQ equation engines.
// Round-robin grant, a single transaction in flight, file_active routed back
// only to the current owner, and a watchdog that frees the port if the file
// controller never answers.
module dsp_file_port_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 1024,
   parameter int TW      = 16
) (
   input  logic                    wb_clk,
   input  logic                    wb_rst_n,
   input  logic [8*NUM_REQ-1:0]    req_file_num,
   input  logic [NUM_REQ-1:0]      req_file_read,
   input  logic [NUM_REQ-1:0]      req_file_write,
   input  logic [32*NUM_REQ-1:0]   req_file_write_data,
   output logic [NUM_REQ-1:0]      req_file_active,
   output logic [31:0]             req_file_read_data,
   output logic [NUM_REQ-1:0]      req_error,
   output logic [NUM_REQ-1:0]      grant,
   output logic                    busy,
   output logic [7:0]              file_num,
   output logic                    file_read,
   output logic                    file_write,
   output logic [31:0]             file_write_data,
   input  logic                    file_active,
   input  logic [31:0]             file_read_data
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam bit WD_EN = (TIMEOUT != 0);
   localparam logic [TW-1:0] WD_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
   localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_ACTIVE,
      S_RELEASE
   } state_t;

   state_t              state_q;
   logic [PW-1:0]       rr_ptr_q;
   logic [PW-1:0]       owner_q;
   logic [TW-1:0]       wdog_q;
   logic [NUM_REQ-1:0]  grant_q;
   logic [NUM_REQ-1:0]  req_error_q;
   logic [7:0]          file_num_q;
   logic                file_read_q;
   logic                file_write_q;
   logic [31:0]         file_wdata_q;

   logic [NUM_REQ-1:0]  pend;
   logic                pick_valid_d;
   logic [PW-1:0]       pick_idx_d;
   logic [PW-1:0]       cand;
   logic [7:0]          pick_num;
   logic [31:0]         pick_wdata;
   logic [31:0]         own_wdata;
   logic                wd_expire;

   // Modulo wrap of the round-robin search position.
   function automatic logic [PW-1:0] wrap_idx(input int unsigned v);
      return PW'(v % NUM_REQ);
   endfunction

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pend
         assign pend[gi] = req_file_read[gi] | req_file_write[gi];
      end
   endgenerate

   // First pending engine at or after rr_ptr; scanned backwards so the closest wins.
   always_comb begin
      pick_valid_d = 1'b0;
      pick_idx_d   = '0;
      cand         = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = wrap_idx(32'(rr_ptr_q) + 32'(k));
         if (pend[cand]) begin
            pick_valid_d = 1'b1;
            pick_idx_d   = cand;
         end
      end
   end

   assign pick_num   = req_file_num[{pick_idx_d, 3'b000} +: 8];
   assign pick_wdata = req_file_write_data[{pick_idx_d, 5'b00000} +: 32];
   assign own_wdata  = req_file_write_data[{owner_q, 5'b00000} +: 32];
   assign wd_expire  = WD_EN && (wdog_q == WD_LAST);

   // Arbiter FSM with registered controller-side strobes, grant and error pulse.
   always_ff @(posedge wb_clk) begin
      if (!wb_rst_n) begin
         state_q      <= S_IDLE;
         rr_ptr_q     <= '0;
         owner_q      <= '0;
         wdog_q       <= '0;
         grant_q      <= '0;
         req_error_q  <= '0;
         file_num_q   <= '0;
         file_read_q  <= 1'b0;
         file_write_q <= 1'b0;
         file_wdata_q <= '0;
      end else begin
         req_error_q <= '0;
         case (state_q)
            S_IDLE: begin
               if (pick_valid_d) begin
                  grant_q      <= NUM_REQ'(1) << pick_idx_d;
                  owner_q      <= pick_idx_d;
                  file_num_q   <= pick_num;
                  file_read_q  <= req_file_read[pick_idx_d];
                  file_write_q <= req_file_write[pick_idx_d] & ~req_file_read[pick_idx_d];
                  file_wdata_q <= pick_wdata;
                  wdog_q       <= '0;
                  state_q      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               file_wdata_q <= own_wdata;
               if (file_active) begin
                  file_read_q  <= 1'b0;
                  file_write_q <= 1'b0;
                  wdog_q       <= '0;
                  state_q      <= S_ACTIVE;
               end else if (wd_expire) begin
                  req_error_q  <= grant_q;
                  file_read_q  <= 1'b0;
                  file_write_q <= 1'b0;
                  state_q      <= S_RELEASE;
               end else begin
                  wdog_q <= wdog_q + TW'(1);
               end
            end
            S_ACTIVE: begin
               if (!file_active) begin
                  state_q <= S_RELEASE;
               end else if (wd_expire) begin
                  req_error_q <= grant_q;
                  state_q     <= S_RELEASE;
               end else begin
                  wdog_q <= wdog_q + TW'(1);
               end
            end
            S_RELEASE: begin
               grant_q  <= '0;
               rr_ptr_q <= (owner_q == LAST_IDX) ? '0 : owner_q + PW'(1);
               state_q  <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_file_active    = {NUM_REQ{file_active}} & grant_q;
   assign req_file_read_data = file_read_data;
   assign req_error          = req_error_q;
   assign grant              = grant_q;
   assign busy               = (state_q != S_IDLE);
   assign file_num           = file_num_q;
   assign file_read          = file_read_q;
   assign file_write         = file_write_q;
   assign file_write_data    = file_wdata_q;

endmodule

// File: tb/tb_dsp_file_port_arbiter.sv
// Directed testbench for dsp_file_port_arbiter (4 engines, 16-cycle watchdog).
module tb_dsp_file_port_arbiter;

   logic          wb_clk = 1'b0;
   logic          wb_rst_n;
   logic [31:0]   req_file_num;
   logic [3:0]    req_rd;
   logic [3:0]    req_wr;
   logic [127:0]  req_wdata;
   logic [3:0]    req_file_active;
   logic [31:0]   req_file_read_data;
   logic [3:0]    req_error;
   logic [3:0]    grant;
   logic          busy;
   logic [7:0]    file_num;
   logic          file_read;
   logic          file_write;
   logic [31:0]   file_write_data;
   logic          file_active;
   logic [31:0]   file_read_data;

   int checks = 0;
   int fails  = 0;

   dsp_file_port_arbiter #(.NUM_REQ(4), .TIMEOUT(16), .TW(16)) dut (
      .wb_clk              (wb_clk),
      .wb_rst_n            (wb_rst_n),
      .req_file_num        (req_file_num),
      .req_file_read       (req_rd),
      .req_file_write      (req_wr),
      .req_file_write_data (req_wdata),
      .req_file_active     (req_file_active),
      .req_file_read_data  (req_file_read_data),
      .req_error           (req_error),
      .grant               (grant),
      .busy                (busy),
      .file_num            (file_num),
      .file_read           (file_read),
      .file_write          (file_write),
      .file_write_data     (file_write_data),
      .file_active         (file_active),
      .file_read_data      (file_read_data)
   );

   always #5 wb_clk = ~wb_clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   task automatic tick();
      @(posedge wb_clk);
      #1;
   endtask

   // Controller model: waits for the strobe, answers with file_active, engine drops its strobe.
   task automatic serve(input logic [3:0] exp_grant, input logic [7:0] exp_num, input int act_cycles);
      int n;
      n = 0;
      while (!(file_read || file_write) && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 20) begin
         fails++;
         $display("FAIL serve_wait: no strobe seen, required grant %b", exp_grant);
      end
      checks++;
      if (grant !== exp_grant) begin
         fails++;
         $display("FAIL serve_grant: got %b required %b", grant, exp_grant);
      end
      checks++;
      if (file_num !== exp_num) begin
         fails++;
         $display("FAIL serve_file_num: got %0d required %0d", file_num, exp_num);
      end
      file_active = 1'b1;
      tick();
      req_rd = req_rd & ~exp_grant;
      req_wr = req_wr & ~exp_grant;
      checks++;
      if (req_file_active !== exp_grant) begin
         fails++;
         $display("FAIL serve_route: req_file_active %b required %b", req_file_active, exp_grant);
      end
      repeat (act_cycles - 1) tick();
      file_active = 1'b0;
      n = 0;
      while (busy && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 20) begin
         fails++;
         $display("FAIL serve_release: busy never dropped for grant %b", exp_grant);
      end
      checks++;
      if (grant !== 4'b0000) begin
         fails++;
         $display("FAIL serve_idle_grant: got %b required 0000", grant);
      end
   endtask

   task automatic test_reset();
      wb_rst_n       = 1'b0;
      req_file_num   = '0;
      req_rd         = '0;
      req_wr         = '0;
      req_wdata      = '0;
      file_active    = 1'b0;
      file_read_data = '0;
      repeat (2) tick();
      checks++;
      if ({grant, req_error, busy} !== 9'd0) begin
         fails++;
         $display("FAIL reset_ctrl: grant %b err %b busy %b required all 0", grant, req_error, busy);
      end
      checks++;
      if ({file_num, file_read, file_write, file_write_data} !== 42'd0) begin
         fails++;
         $display("FAIL reset_port: num %h rd %b wr %b data %h required all 0",
                  file_num, file_read, file_write, file_write_data);
      end
      wb_rst_n = 1'b1;
      tick();
      file_active = 1'b1;
      #1;
      checks++;
      if (req_file_active !== 4'b0000 || busy !== 1'b0) begin
         fails++;
         $display("FAIL idle_active_ignored: rfa %b busy %b required 0000 0", req_file_active, busy);
      end
      file_active = 1'b0;
      tick();
   endtask

   task automatic test_single_read();
      req_file_num[7:0] = 8'd3;
      req_rd[0] = 1'b1;
      tick();
      checks++;
      if (file_read !== 1'b1 || file_num !== 8'd3 || grant !== 4'b0001) begin
         fails++;
         $display("FAIL rd_issue: rd %b num %0d grant %b required 1 3 0001", file_read, file_num, grant);
      end
      tick();
      checks++;
      if (file_read !== 1'b1 || req_file_active !== 4'b0000) begin
         fails++;
         $display("FAIL rd_hold: rd %b rfa %b required 1 0000", file_read, req_file_active);
      end
      tick();
      file_active    = 1'b1;
      file_read_data = 32'hDEADBEEF;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (req_file_active !== 4'b0001 || req_file_read_data !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL rd_route[%0d]: rfa %b data %h required 0001 deadbeef",
                     i, req_file_active, req_file_read_data);
         end
         tick();
         if (i == 0) begin
            checks++;
            if (file_read !== 1'b0) begin
               fails++;
               $display("FAIL rd_drop: file_read %b required 0", file_read);
            end
            req_rd[0] = 1'b0;
         end
      end
      file_active = 1'b0;
      #1;
      checks++;
      if (req_file_active !== 4'b0000) begin
         fails++;
         $display("FAIL rd_route_off: rfa %b required 0000", req_file_active);
      end
      tick();
      checks++;
      if (grant !== 4'b0001 || busy !== 1'b1) begin
         fails++;
         $display("FAIL rd_release: grant %b busy %b required 0001 1", grant, busy);
      end
      tick();
      checks++;
      if (grant !== 4'b0000 || busy !== 1'b0) begin
         fails++;
         $display("FAIL rd_idle: grant %b busy %b required 0000 0", grant, busy);
      end
   endtask

   task automatic test_round_robin();
      wb_rst_n = 1'b0;
      tick();
      wb_rst_n = 1'b1;
      req_file_num = {8'd13, 8'd12, 8'd11, 8'd10};
      req_rd = 4'b1111;
      serve(4'b0001, 8'd10, 2);
      serve(4'b0010, 8'd11, 2);
      serve(4'b0100, 8'd12, 2);
      serve(4'b1000, 8'd13, 2);
      req_rd = 4'b0101;
      serve(4'b0001, 8'd10, 3);
      serve(4'b0100, 8'd12, 1);
   endtask

   task automatic test_write();
      int n;
      req_file_num[23:16] = 8'd7;
      req_wdata[95:64]    = 32'h12345678;
      req_wr[2]           = 1'b1;
      tick();
      checks++;
      if (grant !== 4'b0100 || file_num !== 8'd7 || file_write !== 1'b1 || file_read !== 1'b0) begin
         fails++;
         $display("FAIL wr_issue: grant %b num %0d wr %b rd %b required 0100 7 1 0",
                  grant, file_num, file_write, file_read);
      end
      checks++;
      if (file_write_data !== 32'h12345678) begin
         fails++;
         $display("FAIL wr_data: got %h required 12345678", file_write_data);
      end
      req_wdata[95:64] = 32'hCAFEF00D;
      tick();
      checks++;
      if (file_write_data !== 32'hCAFEF00D || file_write !== 1'b1) begin
         fails++;
         $display("FAIL wr_resample: data %h wr %b required cafef00d 1", file_write_data, file_write);
      end
      file_active = 1'b1;
      tick();
      checks++;
      if (file_write !== 1'b0) begin
         fails++;
         $display("FAIL wr_drop: file_write %b required 0", file_write);
      end
      req_wr = '0;
      tick();
      file_active = 1'b0;
      n = 0;
      while (busy && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 20) begin
         fails++;
         $display("FAIL wr_release: busy stuck %b required 0", busy);
      end
   endtask

   task automatic test_timeout();
      req_rd = 4'b0110;
      tick();
      checks++;
      if (grant !== 4'b0010 || file_read !== 1'b1) begin
         fails++;
         $display("FAIL to_grant: grant %b rd %b required 0010 1", grant, file_read);
      end
      for (int i = 1; i < 16; i++) begin
         tick();
         checks++;
         if (req_error !== 4'b0000) begin
            fails++;
            $display("FAIL to_early[%0d]: req_error %b required 0000", i, req_error);
         end
      end
      tick();
      checks++;
      if (req_error !== 4'b0010 || file_read !== 1'b0) begin
         fails++;
         $display("FAIL to_expire: req_error %b rd %b required 0010 0", req_error, file_read);
      end
      req_rd[1] = 1'b0;
      tick();
      checks++;
      if (req_error !== 4'b0000 || grant !== 4'b0000) begin
         fails++;
         $display("FAIL to_pulse: req_error %b grant %b required 0000 0000", req_error, grant);
      end
      serve(4'b0100, 8'd7, 2);
      req_rd = '0;
   endtask

   task automatic test_reset_mid();
      req_wdata[31:0] = 32'hA5A5A5A5;
      req_rd[0] = 1'b1;
      tick();
      file_active = 1'b1;
      tick();
      tick();
      checks++;
      if (req_file_active !== 4'b0001 || busy !== 1'b1) begin
         fails++;
         $display("FAIL mid_active: rfa %b busy %b required 0001 1", req_file_active, busy);
      end
      wb_rst_n = 1'b0;
      tick();
      checks++;
      if ({grant, req_error, busy, req_file_active} !== 13'd0) begin
         fails++;
         $display("FAIL mid_reset_ctrl: grant %b err %b busy %b rfa %b required all 0",
                  grant, req_error, busy, req_file_active);
      end
      checks++;
      if ({file_num, file_read, file_write, file_write_data} !== 42'd0) begin
         fails++;
         $display("FAIL mid_reset_port: num %h rd %b wr %b data %h required all 0",
                  file_num, file_read, file_write, file_write_data);
      end
      req_rd      = '0;
      file_active = 1'b0;
      wb_rst_n    = 1'b1;
      tick();
      tick();
      checks++;
      if (req_error !== 4'b0000 || busy !== 1'b0) begin
         fails++;
         $display("FAIL mid_after: req_error %b busy %b required 0000 0", req_error, busy);
      end
   endtask

   task automatic test_read_wins();
      req_rd[3] = 1'b1;
      req_wr[3] = 1'b1;
      tick();
      checks++;
      if (grant !== 4'b1000 || file_read !== 1'b1 || file_write !== 1'b0) begin
         fails++;
         $display("FAIL rw_issue: grant %b rd %b wr %b required 1000 1 0", grant, file_read, file_write);
      end
      tick();
      checks++;
      if (file_write !== 1'b0) begin
         fails++;
         $display("FAIL rw_hold: file_write %b required 0", file_write);
      end
      serve(4'b1000, 8'd13, 2);
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_write();
      test_timeout();
      test_reset_mid();
      test_read_wins();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
